addsub_seq: RTL and testbench

- Parametrised, multi-cycle add/subtract unit. It is the next generation of the microcontroller ALU's 16-bit combinational adder/subtractor.
- It processes a WIDTH-bit operation in SLICE-bit chunks, one chunk per clock, using a start/busy/done handshake.
- It produces registered result and flags (carry/borrow, overflow, zero, negative), with signed/unsigned mode.
- It sits beside the ALU datapath. The control FSM starts it and waits on done, which lets wide operands (32/64-bit) share one narrow adder.

---
 rtl/addsub_pkg.sv | 25 ++
 rtl/addsub_seq_slice.sv | 31 +++
 rtl/addsub_seq.sv | 181 ++++++++++++++++++
 tb/tb_addsub_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the sequential add/subtract unit and the ALU
// status register:
//   state_t      - FSM encoding {IDLE, RUN}
//   OP_ADD/OP_SUB- values of the op_sub input
//   FLAG_*       - bit positions in the flag vector {NEG, ZERO, OVER, CARRY}
// ---------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVER  = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_W     = 4;

endpackage

// File: rtl/addsub_seq_slice.sv
// ---------------------------------------------------------------------------
// addsub_slice
// Combinational SLICE-bit adder with carry-in.
// Ports:
//   a, b     - slice operands (b already inverted for subtraction)
//   cin      - carry into bit 0
//   sum      - slice sum
//   cout     - carry out of the top bit
//   cin_msb  - carry into the top bit (used for signed overflow)
// ---------------------------------------------------------------------------
module addsub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             cin_msb
);

    logic [SLICE:0] total;

    assign total = {1'b0, a} + {1'b0, b} + (SLICE+1)'(cin);
    assign sum   = total[SLICE-1:0];
    assign cout  = total[SLICE];
    // The sum bit is a^b^carry_in, so the carry into the top bit falls out
    // of the operands and the sum without a separate chain.
    assign cin_msb = a[SLICE-1] ^ b[SLICE-1] ^ sum[SLICE-1];

endmodule

// File: rtl/addsub_seq.sv
// ---------------------------------------------------------------------------
// addsub_seq
// Multi-cycle add/subtract unit: a WIDTH-bit operation is processed in
// SLICE-bit chunks, one per clock, so wide operands share one narrow adder.
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-high reset
//   start              - request, accepted only while busy=0
//   a, b               - operands, sampled at acceptance
//   op_sub             - 1: a-b, 0: a+b
//   signed_mode        - 1: two's-complement flags, 0: unsigned flags
//   busy               - operation in progress
//   done               - one-cycle pulse, y and flags valid
//   y                  - result, held until the next operation completes
//   carry/over/zero/neg- status flags
// Optional feature: define ADDSUB_SEQ_SAT_EN to saturate y on overflow
// (carry/over still report the raw event).
// ---------------------------------------------------------------------------
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             over,
    output logic             zero,
    output logic             neg
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t              state, state_next;
    logic                accept, last;
    logic [WIDTH-1:0]    a_sh, b_sh, res;
    logic                cy;
    logic [IDX_W-1:0]    idx;
    logic                sub_r, smode_r;
    logic [FLAG_W-1:0]   flags, flags_next;

    logic [SLICE-1:0]    sum;
    logic                cout, cin_msb;
    logic [WIDTH-1:0]    res_next, y_fin;
    logic                carry_ev, over_ev;

`ifdef ADDSUB_SEQ_SAT_EN
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH-1);
    localparam logic [WIDTH-1:0] SMAX = ~SMIN;

    // Clamp a wrapped result. In signed mode an overflowed result has the
    // wrong sign, so a negative-looking y means positive overflow.
    function automatic logic [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] v,
        input logic             smode,
        input logic             sub,
        input logic             cy_ev,
        input logic             ov_ev
    );
        if (smode) begin
            if (ov_ev)
                return v[WIDTH-1] ? SMAX : SMIN;
        end else if (cy_ev) begin
            return sub ? '0 : '1;
        end
        return v;
    endfunction
`endif

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a       (a_sh[SLICE-1:0]),
        .b       (b_sh[SLICE-1:0]),
        .cin     (cy),
        .sum     (sum),
        .cout    (cout),
        .cin_msb (cin_msb)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == IDX_W'(NSLICE-1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // Result slices enter at the top and shift down, so after the last
    // slice the register holds the whole result in place.
    assign res_next = (res >> SLICE) | (WIDTH'(sum) << (WIDTH-SLICE));

    // With ~b+1 subtraction a missing carry out of the MSB is a borrow.
    assign carry_ev = sub_r ? ~cout : cout;
    assign over_ev  = cin_msb ^ cout;

`ifdef ADDSUB_SEQ_SAT_EN
    assign y_fin = saturate(res_next, smode_r, sub_r, carry_ev, over_ev);
`else
    assign y_fin = res_next;
`endif

    always_comb begin
        flags_next             = '0;
        flags_next[FLAG_CARRY] = ~smode_r & carry_ev;
        flags_next[FLAG_OVER]  = smode_r & over_ev;
        flags_next[FLAG_ZERO]  = (y_fin == '0);
        flags_next[FLAG_NEG]   = smode_r & y_fin[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            cy      <= 1'b0;
            idx     <= '0;
            sub_r   <= 1'b0;
            smode_r <= 1'b0;
            y       <= '0;
            flags   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= (op_sub == OP_SUB) ? ~b : b;
                cy      <= op_sub;
                idx     <= '0;
                sub_r   <= op_sub;
                smode_r <= signed_mode;
            end else if (state == RUN) begin
                a_sh <= a_sh >> SLICE;
                b_sh <= b_sh >> SLICE;
                res  <= res_next;
                cy   <= cout;
                idx  <= idx + IDX_W'(1);
                if (last) begin
                    y     <= y_fin;
                    flags <= flags_next;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign carry = flags[FLAG_CARRY];
    assign over  = flags[FLAG_OVER];
    assign zero  = flags[FLAG_ZERO];
    assign neg   = flags[FLAG_NEG];

endmodule

// File: tb/tb_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_addsub_seq
// Scoreboard bench for addsub_seq: a 16/8 instance and a 32/8 instance.
// Expected results come from an independent wide-arithmetic model, are
// queued when an operation is accepted and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_addsub_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start16 = 1'b0, op16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, c16, o16, z16, n16;
    logic [15:0] y16;

    logic        start32 = 1'b0, op32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, c32, o32, z32, n32;
    logic [31:0] y32;

    addsub_seq #(.WIDTH(16), .SLICE(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .op_sub(op16), .signed_mode(sm16), .busy(busy16), .done(done16),
        .y(y16), .carry(c16), .over(o16), .zero(z16), .neg(n16)
    );

    addsub_seq #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .op_sub(op32), .signed_mode(sm32), .busy(busy32), .done(done32),
        .y(y32), .carry(c32), .over(o32), .zero(z32), .neg(n32)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] y;
        logic        c, o, z, n;
        int          acc;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    exp_t hold16, hold32, m16, m32;
    logic prev16 = 1'b0, prev32 = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic op, input logic sm);
        exp_t        e;
        logic [64:0] mask, full;
        logic        cout, borrow, sa, sb, ov;
        mask = (65'd1 << w) - 65'd1;
        if (op) full = {1'b0, a} + ({1'b0, ~b} & mask) + 65'd1;
        else    full = {1'b0, a} + {1'b0, b};
        cout   = full[w];
        borrow = (a < b);
        e.y    = full[63:0] & mask[63:0];
        sa     = a[w-1];
        sb     = op ? ~b[w-1] : b[w-1];
        ov     = (sa == sb) && (e.y[w-1] != sa);
        e.c    = sm ? 1'b0 : (op ? borrow : cout);
        e.o    = sm ? ov : 1'b0;
`ifdef ADDSUB_SEQ_SAT_EN
        if (sm && ov)
            e.y = sa ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
        else if (!sm && !op && cout)
            e.y = mask[63:0];
        else if (!sm && op && borrow)
            e.y = 64'd0;
`endif
        e.z   = (e.y == 64'd0);
        e.n   = sm & e.y[w-1];
        e.acc = 0;
        return e;
    endfunction

    // Called on a falling edge with the target idle; returns on the falling
    // edge after the acceptance edge.
    task automatic issue(input int sel, input logic [63:0] a, input logic [63:0] b,
                         input logic op, input logic sm);
        exp_t e;
        if (sel == 16) begin
            a = a & 64'hFFFF;
            b = b & 64'hFFFF;
            a16 = a[15:0]; b16 = b[15:0]; op16 = op; sm16 = sm; start16 = 1'b1;
        end else begin
            a = a & 64'hFFFF_FFFF;
            b = b & 64'hFFFF_FFFF;
            a32 = a[31:0]; b32 = b[31:0]; op32 = op; sm32 = sm; start32 = 1'b1;
        end
        e = model(sel, a, b, op, sm);
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        start32 = 1'b0;
        e.acc = cyc;
        if (sel == 16) begin
            q16.push_back(e);
            check("busy16_after_start", busy16, 1'b1);
            check("done16_after_start", done16, 1'b0);
        end else begin
            q32.push_back(e);
            check("busy32_after_start", busy32, 1'b1);
        end
    endtask

    task automatic wait_done(input int sel);
        int n = 0;
        while (((sel == 16) ? done16 : done32) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done%0d_seen", sel), (sel == 16) ? done16 : done32, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done16) begin
                check("done16_single_cycle", prev16, 1'b0);
                if (q16.size() == 0) begin
                    check("done16_unexpected", done16, 1'b0);
                end else begin
                    m16 = q16.pop_front();
                    check("y16",       y16, m16.y);
                    check("carry16",   c16, m16.c);
                    check("over16",    o16, m16.o);
                    check("zero16",    z16, m16.z);
                    check("neg16",     n16, m16.n);
                    check("latency16", cyc - m16.acc, 2);
                    check("busy16_at_done", busy16, 1'b0);
                    hold16 = m16;
                end
            end
            prev16 = done16;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done32) begin
                check("done32_single_cycle", prev32, 1'b0);
                if (q32.size() == 0) begin
                    check("done32_unexpected", done32, 1'b0);
                end else begin
                    m32 = q32.pop_front();
                    check("y32",       y32, m32.y);
                    check("carry32",   c32, m32.c);
                    check("over32",    o32, m32.o);
                    check("zero32",    z32, m32.z);
                    check("neg32",     n32, m32.n);
                    check("latency32", cyc - m32.acc, 4);
                    hold32 = m32;
                end
            end
            prev32 = done32;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy16",  busy16, 1'b0);
        check("rst_done16",  done16, 1'b0);
        check("rst_y16",     y16, 16'h0000);
        check("rst_carry16", c16, 1'b0);
        check("rst_over16",  o16, 1'b0);
        check("rst_zero16",  z16, 1'b0);
        check("rst_neg16",   n16, 1'b0);
        check("rst_y32",     y32, 32'h0);
        check("rst_busy32",  busy32, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed corner cases; each new op starts on the done cycle of
        // the previous one, so back-to-back acceptance is exercised too.
        issue(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0); wait_done(16);
        issue(16, 64'h0003, 64'h0005, 1'b1, 1'b0); wait_done(16);
        issue(16, 64'h7FFF, 64'h0001, 1'b0, 1'b1); wait_done(16);
        issue(16, 64'h8000, 64'h0001, 1'b1, 1'b1); wait_done(16);
        issue(16, 64'hFFFF, 64'h0001, 1'b0, 1'b1); wait_done(16);
        issue(16, 64'h0000, 64'h0000, 1'b1, 1'b0); wait_done(16);
        issue(16, 64'h8000, 64'h8000, 1'b0, 1'b1); wait_done(16);

        for (int i = 0; i < 10; i++) begin
            issue(16, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            wait_done(16);
        end

        // Result holds after done and across the start of the next op.
        repeat (3) @(negedge clk);
        check("hold_y16_idle", y16, hold16.y);
        check("hold_c16_idle", c16, hold16.c);
        issue(16, 64'h1234, 64'h1111, 1'b0, 1'b0);
        check("hold_y16_running", y16, hold16.y);

        // Start while busy: different operands, must be ignored.
        a16 = 16'hFFFF; b16 = 16'hFFFF; op16 = 1'b1; sm16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        wait_done(16);
        repeat (4) @(negedge clk);
        check("ignored_start_busy16", busy16, 1'b0);
        check("ignored_start_y16", y16, 16'h2345);

        // Reset after the first slice aborts the operation with no done.
        issue(16, 64'h0005, 64'h0006, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy16",  busy16, 1'b0);
        check("abort_done16",  done16, 1'b0);
        check("abort_y16",     y16, 16'h0000);
        check("abort_zero16",  z16, 1'b0);
        check("abort_carry16", c16, 1'b0);
        q16.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done16", done16, 1'b0);
        check("abort_y16_after", y16, 16'h0000);

        // Wider instance, four slices per op.
        issue(32, 64'h0000_FFFF, 64'h0000_0001, 1'b0, 1'b0); wait_done(32);
        issue(32, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 1'b0); wait_done(32);
        issue(32, 64'h8000_0000, 64'h0000_0001, 1'b1, 1'b1); wait_done(32);
        for (int i = 0; i < 4; i++) begin
            issue(32, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            wait_done(32);
        end

        repeat (3) @(negedge clk);
        check("q16_drained", q16.size(), 0);
        check("q32_drained", q32.size(), 0);
        check("hold_y32_idle", y32, hold32.y);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
